// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: time-shares one combinational ALU between two requesters
// (0 = main execute path, 1 = address/aux path) with round-robin arbitration.
// Operands are registered before the ALU; result and ZERO flag are registered
// and returned on the winning requester's response channel.
// Optional build macro: ARB_B2B_EN lets a new request be accepted in the same
// cycle a response is taken, giving one op every two cycles.
//
// Handshake rules (both channels): a transfer happens on a rising clock edge
// where valid and ready for the same requester bit are both high. req_ready is
// combinational from req_valid and state and is never high for more than one
// requester. rsp_valid/rsp_data/rsp_zero stay stable until rsp_ready of the
// owning requester is seen.
module alu_share_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ALUCTRL_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 req_valid,
  output logic [1:0]                 req_ready,
  input  logic [2*ALUCTRL_WIDTH-1:0] req_ctrl,
  input  logic [2*DATA_WIDTH-1:0]    req_op1,
  input  logic [2*DATA_WIDTH-1:0]    req_op2,
  output logic [1:0]                 rsp_valid,
  input  logic [1:0]                 rsp_ready,
  output logic [DATA_WIDTH-1:0]      rsp_data,
  output logic                       rsp_zero,
  output logic [ALUCTRL_WIDTH-1:0]   alu_ctrl,
  output logic [DATA_WIDTH-1:0]      alu_op1,
  output logic [DATA_WIDTH-1:0]      alu_op2,
  input  logic [DATA_WIDTH-1:0]      alu_sum,
  input  logic                       alu_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // state is the observable FSM state for checkers bound to this block
  state_t state;
  state_t state_nxt;

  logic                     rr_ptr;
  logic                     owner;
  logic                     winner;
  logic                     rsp_hs;
  logic                     grant_en;
  logic                     accept;
  logic [ALUCTRL_WIDTH-1:0] win_ctrl;
  logic [DATA_WIDTH-1:0]    win_op1;
  logic [DATA_WIDTH-1:0]    win_op2;

  // Round-robin pick: the pointed-to requester if valid, otherwise the other one
  always_comb begin
    winner   = req_valid[rr_ptr] ? rr_ptr : ~rr_ptr;
    win_ctrl = winner ? req_ctrl[ALUCTRL_WIDTH +: ALUCTRL_WIDTH] : req_ctrl[0 +: ALUCTRL_WIDTH];
    win_op1  = winner ? req_op1[DATA_WIDTH +: DATA_WIDTH] : req_op1[0 +: DATA_WIDTH];
    win_op2  = winner ? req_op2[DATA_WIDTH +: DATA_WIDTH] : req_op2[0 +: DATA_WIDTH];
  end

  // Grant window and handshake decode; rst_n gate keeps req_ready low during reset
  always_comb begin
    rsp_hs = (state == RESP) && rsp_ready[owner];
`ifdef ARB_B2B_EN
    grant_en = (state == IDLE) || rsp_hs;
`else
    grant_en = (state == IDLE);
`endif
    accept    = rst_n && grant_en && (|req_valid);
    req_ready = accept ? (winner ? 2'b10 : 2'b01) : 2'b00;
    rsp_valid = (state == RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
  end

  // Next-state logic: IDLE -> EXEC -> RESP -> IDLE (or RESP -> EXEC on a back-to-back grant)
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_hs) state_nxt = accept ? EXEC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Operand capture on grant; alu_* hold the last accepted op while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_ctrl <= '0;
      alu_op1  <= '0;
      alu_op2  <= '0;
      owner    <= 1'b0;
      rr_ptr   <= 1'b0;
    end else if (accept) begin
      alu_ctrl <= win_ctrl;
      alu_op1  <= win_op1;
      alu_op2  <= win_op2;
      owner    <= winner;
      rr_ptr   <= ~winner;
    end
  end

  // Result capture one cycle after the operands reach the ALU
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data <= '0;
      rsp_zero <= 1'b0;
    end else if (state == EXEC) begin
      rsp_data <= alu_sum;
      rsp_zero <= alu_zero;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: randomized and directed stimulus against a
// transaction-level reference (busy flag, last-grant memory, fixed latency,
// expected-result queues). Build with +define+ARB_B2B_EN for the
// back-to-back variant.
module tb_alu_share_arbiter;
  localparam int W = 32;
  localparam int C = 4;
`ifdef ARB_B2B_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
  logic [2*C-1:0] req_ctrl;
  logic [2*W-1:0] req_op1, req_op2;
  logic [W-1:0]   rsp_data, alu_op1, alu_op2, alu_sum;
  logic           rsp_zero, alu_zero;
  logic [C-1:0]   alu_ctrl;

  alu_share_arbiter #(.DATA_WIDTH(W), .ALUCTRL_WIDTH(C)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_ctrl(req_ctrl), .req_op1(req_op1), .req_op2(req_op2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero),
    .alu_ctrl(alu_ctrl), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_sum(alu_sum), .alu_zero(alu_zero)
  );

  // Behavioural ALU (RV32-style ALUCtrl = {func7[5], func3}); unknown codes give 0
  function automatic logic [W-1:0] alu_ref(logic [C-1:0] c, logic [W-1:0] a, logic [W-1:0] b);
    case (c)
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b0111: return a & b;
      4'b0110: return a | b;
      4'b0100: return a ^ b;
      4'b0001: return a << b[4:0];
      4'b0101: return a >> b[4:0];
      4'b1101: return $unsigned($signed(a) >>> b[4:0]);
      4'b0010: return {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      4'b0011: return {{(W-1){1'b0}}, (a < b)};
      default: return '0;
    endcase
  endfunction

  assign alu_sum  = alu_ref(alu_ctrl, alu_op1, alu_op2);
  assign alu_zero = (alu_sum == '0);

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic         exp_z_q[$];
  logic         m_busy, m_last, m_owner;
  int           m_acc_cyc;
  logic [C-1:0] m_ctrl;
  logic [W-1:0] m_op1, m_op2;
  int           n_rsp, n_gnt0, n_gnt1;
  logic [W-1:0] last_data;
  logic         last_zero, last_id;
  // monitor scratch
  logic [1:0]   e_ready, e_rsp;
  logic         rsp_now, can_grant, win;
  logic [W-1:0] a_w, b_w, r_w;

  initial begin
    m_busy = 1'b0; m_last = 1'b1; m_owner = 1'b0; m_acc_cyc = 0;
    m_ctrl = '0; m_op1 = '0; m_op2 = '0;
    n_rsp = 0; n_gnt0 = 0; n_gnt1 = 0;
    last_data = '0; last_zero = 1'b0; last_id = 1'b0;
  end

  // Per-cycle comparison, sampled mid-cycle; then advance the model for the coming edge
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_req_ready", req_ready, 2'b00);
      check("rst_rsp_valid", rsp_valid, 2'b00);
      check("rst_rsp_data",  rsp_data, 0);
      check("rst_rsp_zero",  rsp_zero, 0);
      check("rst_alu",       {alu_ctrl, alu_op1, alu_op2}, 0);
      m_busy = 1'b0; m_last = 1'b1; m_owner = 1'b0;
      m_ctrl = '0; m_op1 = '0; m_op2 = '0;
      exp_q.delete(); exp_z_q.delete();
    end else begin
      rsp_now   = m_busy && (cyc >= m_acc_cyc + 2);
      can_grant = !m_busy || (B2B && rsp_now && rsp_ready[m_owner]);
      win       = (req_valid == 2'b11) ? ~m_last : req_valid[1];
      e_ready   = (can_grant && (|req_valid)) ? (2'b01 << win) : 2'b00;
      e_rsp     = rsp_now ? (2'b01 << m_owner) : 2'b00;
      check("req_ready", req_ready, e_ready);
      check("rsp_valid", rsp_valid, e_rsp);
      check("alu_ctrl", alu_ctrl, m_ctrl);
      check("alu_op1",  alu_op1,  m_op1);
      check("alu_op2",  alu_op2,  m_op2);
      if (rsp_now) begin
        if (exp_q.size() > 0) begin
          check("rsp_data", rsp_data, exp_q[0]);
          check("rsp_zero", rsp_zero, exp_z_q[0]);
        end
        if (rsp_ready[m_owner]) begin
          last_data = rsp_data; last_zero = rsp_zero; last_id = m_owner;
          void'(exp_q.pop_front()); void'(exp_z_q.pop_front());
          m_busy = 1'b0;
          n_rsp++;
        end
      end
      if (e_ready != 2'b00) begin
        a_w = win ? req_op1[W +: W] : req_op1[0 +: W];
        b_w = win ? req_op2[W +: W] : req_op2[0 +: W];
        m_ctrl = win ? req_ctrl[C +: C] : req_ctrl[0 +: C];
        m_op1 = a_w; m_op2 = b_w;
        r_w = alu_ref(m_ctrl, a_w, b_w);
        exp_q.push_back(r_w);
        exp_z_q.push_back(r_w == '0);
        m_busy = 1'b1; m_owner = win; m_last = win; m_acc_cyc = cyc;
        if (win) n_gnt1++; else n_gnt0++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic [C-1:0] op_tab [0:10];
  initial op_tab = '{4'b0000, 4'b1000, 4'b0111, 4'b0110, 4'b0100, 4'b0001,
                     4'b0101, 4'b1101, 4'b0010, 4'b0011, 4'b1111};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [C-1:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    if (i == 0) begin
      req_ctrl[0 +: C] = c; req_op1[0 +: W] = a; req_op2[0 +: W] = b;
    end else begin
      req_ctrl[C +: C] = c; req_op1[W +: W] = a; req_op2[W +: W] = b;
    end
  endtask

  task automatic rand_ops();
    logic [W-1:0] a, b;
    for (int i = 0; i < 2; i++) begin
      a = $urandom();
      b = ($urandom_range(0, 3) == 0) ? a : W'($urandom());
      set_req(i, op_tab[$urandom_range(0, 10)], a, b);
    end
  endtask

  // Wait (bounded) until the model has no operation in flight
  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (m_busy && n < 30) begin
      step();
      n++;
    end
    if (m_busy) check({tag, "_timeout"}, 1, 0);
  endtask

  // ---------------- stimulus ----------------
  int rsp_before;

  initial begin
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    req_ctrl = '0; req_op1 = '0; req_op2 = '0;
    rand_ops();
    rst_n = 1'b0;
    repeat (4) step();

    // Reset release with both requesting: requester 0 must be granted first
    rst_n = 1'b1;
    @(negedge clk);
    check("first_grant", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    wait_idle("reset_drain");
    step();

    // Single op on requester 0: 5 + 7
    set_req(0, 4'b0000, 32'd5, 32'd7);
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    wait_idle("single");
    check("single_data", last_data, 12);
    check("single_zero", last_zero, 0);
    check("single_id",   last_id,   0);

    // Zero flag and routing to requester 1: 9 - 9
    set_req(1, 4'b1000, 32'd9, 32'd9);
    req_valid = 2'b10;
    step();
    req_valid = 2'b00;
    wait_idle("zero");
    check("zero_data", last_data, 0);
    check("zero_flag", last_zero, 1);
    check("zero_id",   last_id,   1);

    // Backpressure: response held for several cycles before being taken
    rsp_ready = 2'b00;
    set_req(0, 4'b0110, 32'h00f0, 32'h0f00);
    req_valid = 2'b01;
    step();
    req_valid = 2'b11;
    repeat (8) step();
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    wait_idle("backpressure");
    check("bp_data", last_data, 32'h0ff0);

    // Contention: both valid, responses always taken; grants must alternate
    n_gnt0 = 0; n_gnt1 = 0;
    req_valid = 2'b11;
    for (int k = 0; k < 40; k++) begin
      rand_ops();
      step();
    end
    req_valid = 2'b00;
    wait_idle("contention");
    check("fair_balance", ((n_gnt0 - n_gnt1) <= 1 && (n_gnt1 - n_gnt0) <= 1), 1);
    check("fair_progress", (n_gnt0 >= 5 && n_gnt1 >= 5), 1);

    // Randomized traffic with dropping valids and random backpressure
    for (int k = 0; k < 3000; k++) begin
      req_valid = 2'($urandom_range(0, 3));
      rsp_ready = 2'($urandom_range(0, 3));
      rand_ops();
      step();
    end
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    wait_idle("random");

    // Reset while the op is in EXEC: no response may ever appear
    step();
    rsp_before = n_rsp;
    set_req(0, 4'b0000, 32'd1, 32'd2);
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (6) step();
    check("midreset_no_rsp", n_rsp, rsp_before);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time bound
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
